// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset datapath: PC, IR, MDR, A, B, ALUOut, 32x32 register
// file and ALU, steered cycle by cycle by the external control FSM.
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_Write,
  input  logic        I_or_D,
  input  logic        Mem_Write,
  input  logic        IR_Write,
  input  logic        Reg_Dst,
  input  logic        Mem_to_Reg,
  input  logic        Reg_Write,
  input  logic        ALU_Src_A,
  input  logic [1:0]  ALU_Src_B,
  input  logic [1:0]  ALU_Op,
  input  logic        PC_Src,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        Zero,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_fn_e;

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_alu_out;
  logic [31:0] r_rf [32];

  logic [31:0] w_imm;
  logic [31:0] w_src_a;
  logic [31:0] w_src_b;
  logic [31:0] w_alu_res;
  alu_fn_e     w_alu_fn;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;

  assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_src_a   = ALU_Src_A ? r_a : r_pc;
  assign w_wr_addr = Reg_Dst ? r_ir[15:11] : r_ir[20:16];
  assign w_wr_data = Mem_to_Reg ? r_mdr : r_alu_out;

  assign mem_addr  = I_or_D ? r_alu_out : r_pc;
  assign mem_wdata = r_b;
  assign mem_we    = Mem_Write;
  assign Op        = r_ir[31:26];
  assign Funct     = r_ir[5:0];
  assign Zero      = (w_alu_res == 32'd0);
  // r0 is never written, but the debug port still masks it explicitly.
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : r_rf[dbg_raddr];

  // ALU B operand select.
  always_comb begin
    w_src_b = r_b;
    unique case (ALU_Src_B)
      2'b00:   w_src_b = r_b;
      2'b01:   w_src_b = PC_INC;
      2'b10:   w_src_b = w_imm;
      default: w_src_b = {w_imm[29:0], 2'b00};
    endcase
  end

  // ALU function decode; unknown Funct codes fall back to add.
  always_comb begin
    w_alu_fn = AluAdd;
    unique case (ALU_Op)
      2'b01: w_alu_fn = AluSub;
      2'b10: begin
        case (r_ir[5:0])
          6'h22:   w_alu_fn = AluSub;
          6'h24:   w_alu_fn = AluAnd;
          6'h25:   w_alu_fn = AluOr;
          6'h2A:   w_alu_fn = AluSlt;
          default: w_alu_fn = AluAdd;
        endcase
      end
      default: w_alu_fn = AluAdd;
    endcase
  end

  // ALU datapath, 32-bit wrap-around.
  always_comb begin
    w_alu_res = w_src_a + w_src_b;
    unique case (w_alu_fn)
      AluSub:  w_alu_res = w_src_a - w_src_b;
      AluAnd:  w_alu_res = w_src_a & w_src_b;
      AluOr:   w_alu_res = w_src_a | w_src_b;
      AluSlt:  w_alu_res = {31'd0, $signed(w_src_a) < $signed(w_src_b)};
      default: w_alu_res = w_src_a + w_src_b;
    endcase
  end

  // Architectural and pipeline-like holding registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_mdr     <= 32'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_alu_out <= 32'd0;
    end else begin
      if (PC_Write) begin
        r_pc <= PC_Src ? r_alu_out : w_alu_res;
      end
      if (IR_Write) begin
        r_ir <= mem_rdata;
      end
      r_mdr     <= mem_rdata;
      r_a       <= r_rf[r_ir[25:21]];
      r_b       <= r_rf[r_ir[20:16]];
      r_alu_out <= w_alu_res;
    end
  end

  // Register file write port; reads are asynchronous so same-cycle reads see old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        r_rf[i] <= 32'd0;
      end
    end else if (Reg_Write && (w_wr_addr != 5'd0)) begin
      r_rf[w_wr_addr] <= w_wr_data;
    end
  end

endmodule
